instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
IF stage of the 5-stage MIPS pipeline, directly upstream of decode/control.
- Owns the PC and the instruction-memory request handshake.
- Owns the IF/ID pipeline register, which drives Opcode/FuncCode into the control unit plus a fetch bubble.
- Honours Stall from the hazard unit and Redirect (taken branch/jump) from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, PC/address width.

Ports:
- CLK  input  1  pipeline clock; all state on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ImemAddr  output  PC_W  address of the outstanding request; stable while ImemReq=1 and ImemReady=0.
- ImemReq  output  1  fetch request.
- ImemData  input  32  instruction word; valid when ImemReq & ImemReady.
- ImemReady  input  1  memory completes the request this cycle; may be combinationally high.
- Stall  input  1  hold IF/ID and PC (load-use hazard).
- Redirect  input  1  flush and restart fetch at RedirectPC.
- RedirectPC  input  PC_W  target; bits [1:0] ignored (forced 0).
- IfIdInstr  output  32  registered instruction.
- IfIdPCPlus4  output  PC_W  registered fetch address + 4.
- IfIdValid  output  1  IF/ID holds a real instruction.
- Opcode  output  6  IfIdInstr[31:26], to control unit.
- FuncCode  output  6  IfIdInstr[5:0], to control unit.
- FetchBubble  output  1  ~IfIdValid; ORed with the hazard bubble before the control unit.

Behaviour:
Reset (async):
- PC=RESET_PC, ReqAddr=RESET_PC, state=FETCH.
- IfIdInstr=0, IfIdPCPlus4=0, IfIdValid=0, hold buffer empty.
- ImemReq=0 while Reset is high.

FETCH state:
- ImemReq=1, ImemAddr=ReqAddr.
- Accept (ImemReady=1):
  - Redirect: data dropped; PC and ReqAddr <= RedirectPC; IfIdValid<=0.
  - Else Stall: data and ReqAddr+4 go to the hold buffer; PC <= ReqAddr+4; IF/ID unchanged; go HOLD.
  - Else: IfIdInstr<=ImemData, IfIdPCPlus4<=ReqAddr+4, IfIdValid<=1; PC and ReqAddr <= ReqAddr+4.
- No accept:
  - Redirect: PC<=RedirectPC; IfIdValid<=0; go DISCARD (ReqAddr must stay stable).
  - Else !Stall: IfIdValid<=0 (bubble).
  - Else: IF/ID held.

DISCARD state:
- ImemReq=1 at the old ReqAddr.
- On ImemReady: data dropped; ReqAddr<=PC; go FETCH.
- A further Redirect only updates PC.
- IfIdValid stays 0.

HOLD state:
- ImemReq=0.
- Redirect: buffer discarded; PC and ReqAddr <= RedirectPC; IfIdValid<=0; go FETCH.
- Else !Stall: IF/ID <= buffer, IfIdValid<=1; ReqAddr<=PC; go FETCH.

Priority and timing:
- Redirect > Stall, in every state. Redirect always clears IfIdValid the next cycle, even while stalled.
- Throughput is 1 instruction/cycle with ImemReady tied high. IF/ID is valid the cycle after accept.

Arithmetic and invariants:
- All PC arithmetic is modulo 2^PC_W; 32'hFFFF_FFFC + 4 = 0.
- The request address never changes mid-handshake.

Optional Feature:
IFETCH_PERF_CNT_EN
- Defined: adds outputs FetchCount (32) and StallCycles (32), reset to 0.
  - FetchCount increments on each instruction loaded into IF/ID with IfIdValid=1.
  - StallCycles increments each cycle Stall=1.
  - Both counters wrap at 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package: state encoding (FETCH/DISCARD/HOLD), NOP_INSTR=32'h0, the OPCODE/FUNCT field bit positions shared with decode.
- One sub-module: if_id_pipe_reg. It holds Instr/PCPlus4/Valid with load, hold and flush controls; the FSM stays in the parent.

Test Plan:
- Reset release, ImemReady=1 always, imem[0]=32'h8C010004 -> ImemAddr 0,4,8 on consecutive cycles; cycle 2 Opcode=6'b100011, IfIdPCPlus4=4, IfIdValid=1.
- Stall high for 3 cycles mid-stream -> IF/ID frozen; one word buffered, ImemReq=0 while in HOLD; after release there is no lost or duplicated instruction (sequence 0,4,8,C).
- ImemReady delayed 3 cycles, then Redirect to 32'h40 during the wait -> ImemAddr held at old address until ready; that data dropped; next request at 0x40; IfIdValid=0 throughout.
- Redirect and Stall asserted together with RedirectPC=32'h103 -> IfIdValid=0 next cycle; next ImemAddr=32'h100.
- PC at 32'hFFFF_FFFC accepted -> IfIdPCPlus4=0 and next ImemAddr=0.
- Reset asserted while in HOLD with a buffered word -> all outputs return to reset values immediately (async); after release the first ImemAddr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the IF stage and the decode stage downstream of it:
// fetch FSM state encoding, the NOP word that fills an empty IF/ID register,
// and the instruction field positions that decode also slices.
package instruction_fetch_unit_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_FETCH   = 2'd0;
    localparam fetch_state_t ST_DISCARD = 2'd1;
    localparam fetch_state_t ST_HOLD    = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request bus. The fetch unit is the master; the memory
// completes a request in any cycle where imem_req and imem_ready are both high.
interface instruction_fetch_unit_if #(parameter int PC_W = 32);
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic [31:0]     imem_data;
    logic            imem_ready;

    modport master (output imem_addr, output imem_req, input imem_data, input imem_ready);
    modport slave  (input imem_addr, input imem_req, output imem_data, output imem_ready);
endinterface

// File: rtl/instruction_fetch_unit_if_id_pipe_reg.sv
// IF/ID pipeline register. Flush only drops the valid bit (the payload is
// don't-care once invalid); load captures a new instruction; otherwise it holds.
module instruction_fetch_unit_if_id_pipe_reg
    import instruction_fetch_unit_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [31:0]     load_instr,
    input  logic [PC_W-1:0] load_pc_plus4,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc_plus4,
    output logic            valid
);

    // Flush wins over load so a redirect can never leak a stale instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            instr    <= load_instr;
            pc_plus4 <= load_pc_plus4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: PC, instruction-memory handshake and
// the IF/ID register feeding decode. Redirect always beats Stall.
// Optional build macro IFETCH_PERF_CNT_EN adds fetch_count / stall_cycles.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_fetch_unit_if.master imem,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic [31:0]              if_id_instr,
    output logic [PC_W-1:0]          if_id_pc_plus4,
    output logic                     if_id_valid,
    output logic [5:0]               opcode,
    output logic [5:0]               func_code,
    output logic                     fetch_bubble
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]              fetch_count,
    output logic [31:0]              stall_cycles
`endif
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    logic [PC_W-1:0] req_addr, req_addr_next;
    logic [PC_W-1:0] req_addr_plus4;
    logic [PC_W-1:0] redirect_target;
    logic [31:0]     hold_instr;
    logic [PC_W-1:0] hold_pc_plus4;
    logic            hold_capture;
    logic            pipe_load;
    logic            pipe_flush;
    logic [31:0]     pipe_instr;
    logic [PC_W-1:0] pipe_pc_plus4;

    assign req_addr_plus4  = req_addr + PC_W'(4);
    assign redirect_target = redirect_pc & ~PC_W'(3);

    assign imem.imem_addr = req_addr;
    assign imem.imem_req  = !rst && (state == ST_FETCH || state == ST_DISCARD);

    // Next-state decode: FETCH streams, DISCARD drains a request orphaned by a
    // redirect (its address must not move), HOLD parks a word accepted under stall.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        pipe_load     = 1'b0;
        pipe_flush    = 1'b0;
        hold_capture  = 1'b0;
        pipe_instr    = imem.imem_data;
        pipe_pc_plus4 = req_addr_plus4;
        case (state)
            ST_FETCH: begin
                if (imem.imem_ready) begin
                    if (redirect) begin
                        pc_next       = redirect_target;
                        req_addr_next = redirect_target;
                        pipe_flush    = 1'b1;
                    end else if (stall) begin
                        hold_capture = 1'b1;
                        pc_next      = req_addr_plus4;
                        state_next   = ST_HOLD;
                    end else begin
                        pipe_load     = 1'b1;
                        pc_next       = req_addr_plus4;
                        req_addr_next = req_addr_plus4;
                    end
                end else if (redirect) begin
                    pc_next    = redirect_target;
                    pipe_flush = 1'b1;
                    state_next = ST_DISCARD;
                end else if (!stall) begin
                    pipe_flush = 1'b1;
                end
            end
            ST_DISCARD: begin
                pipe_flush = 1'b1;
                if (redirect) begin
                    pc_next = redirect_target;
                end
                if (imem.imem_ready) begin
                    req_addr_next = redirect ? redirect_target : pc;
                    state_next    = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_next       = redirect_target;
                    req_addr_next = redirect_target;
                    pipe_flush    = 1'b1;
                    state_next    = ST_FETCH;
                end else if (!stall) begin
                    pipe_load     = 1'b1;
                    pipe_instr    = hold_instr;
                    pipe_pc_plus4 = hold_pc_plus4;
                    req_addr_next = pc;
                    state_next    = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Fetch FSM state, PC, request address and the one-word hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_FETCH;
            pc            <= RESET_PC;
            req_addr      <= RESET_PC;
            hold_instr    <= NOP_INSTR;
            hold_pc_plus4 <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
            if (hold_capture) begin
                hold_instr    <= imem.imem_data;
                hold_pc_plus4 <= req_addr_plus4;
            end
        end
    end

    instruction_fetch_unit_if_id_pipe_reg #(.PC_W(PC_W)) u_if_id (
        .clk           (clk),
        .rst           (rst),
        .load          (pipe_load),
        .flush         (pipe_flush),
        .load_instr    (pipe_instr),
        .load_pc_plus4 (pipe_pc_plus4),
        .instr         (if_id_instr),
        .pc_plus4      (if_id_pc_plus4),
        .valid         (if_id_valid)
    );

    assign opcode       = opcode_of(if_id_instr);
    assign func_code    = funct_of(if_id_instr);
    assign fetch_bubble = ~if_id_valid;

`ifdef IFETCH_PERF_CNT_EN
    // Performance counters: instructions delivered to IF/ID and stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if (pipe_load && !pipe_flush) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ready = 1'b0;

    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [5:0]  opcode;
    logic [5:0]  func_code;
    logic        fetch_bubble;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;
`endif

    int compared = 0;
    int mismatched = 0;

    instruction_fetch_unit_if #(.PC_W(32)) imem_bus ();

    // Instruction memory contents: word 0 is lw $1,4($0), others derive from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8C01_0004;
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    assign imem_bus.imem_ready = ready;
    assign imem_bus.imem_data  = mem_word(imem_bus.imem_addr);

    instruction_fetch_unit #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_bus.master),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .opcode         (opcode),
        .func_code      (func_code),
        .fetch_bubble   (fetch_bubble)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        ready = rdy;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared++; if (imem_bus.imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_req: got %b want 0", imem_bus.imem_req); end
        compared++; if (if_id_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid: got %b want 0", if_id_valid); end
        compared++; if (if_id_instr !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_instr: got %h want 0", if_id_instr); end
        compared++; if (if_id_pc_plus4 !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_pc4: got %h want 0", if_id_pc_plus4); end
        compared++; if (fetch_bubble !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_bubble: got %b want 1", fetch_bubble); end
        rst = 1'b0;
        #1;
        compared++; if (imem_bus.imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL rel_req: got %b want 1", imem_bus.imem_req); end
        compared++; if (imem_bus.imem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL rel_addr: got %h want 0", imem_bus.imem_addr); end
    endtask

    task automatic test_fetch_stream();
        do_reset(1'b1);
        step();
        compared++; if (imem_bus.imem_addr !== 32'h4) begin mismatched++; $display("[TB] FAIL stream_addr1: got %h want 4", imem_bus.imem_addr); end
        compared++; if (opcode !== 6'b100011) begin mismatched++; $display("[TB] FAIL stream_opcode: got %b want 100011", opcode); end
        compared++; if (func_code !== 6'b000100) begin mismatched++; $display("[TB] FAIL stream_funct: got %b want 000100", func_code); end
        compared++; if (if_id_pc_plus4 !== 32'h4) begin mismatched++; $display("[TB] FAIL stream_pc4_1: got %h want 4", if_id_pc_plus4); end
        compared++; if (if_id_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stream_valid: got %b want 1", if_id_valid); end
        step();
        compared++; if (imem_bus.imem_addr !== 32'h8) begin mismatched++; $display("[TB] FAIL stream_addr2: got %h want 8", imem_bus.imem_addr); end
        compared++; if (if_id_pc_plus4 !== 32'h8) begin mismatched++; $display("[TB] FAIL stream_pc4_2: got %h want 8", if_id_pc_plus4); end
        compared++; if (if_id_instr !== mem_word(32'h4)) begin mismatched++; $display("[TB] FAIL stream_instr2: got %h want %h", if_id_instr, mem_word(32'h4)); end
    endtask

    task automatic test_stall();
        do_reset(1'b1);
        step();
        stall = 1'b1;
        step();
        compared++; if (imem_bus.imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_req: got %b want 0", imem_bus.imem_req); end
        compared++; if (if_id_pc_plus4 !== 32'h4) begin mismatched++; $display("[TB] FAIL hold_pc4: got %h want 4", if_id_pc_plus4); end
        step();
        step();
        compared++; if (if_id_instr !== 32'h8C01_0004) begin mismatched++; $display("[TB] FAIL hold_instr: got %h want 8c010004", if_id_instr); end
        compared++; if (if_id_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_valid: got %b want 1", if_id_valid); end
`ifdef IFETCH_PERF_CNT_EN
        compared++; if (stall_cycles !== 32'd3) begin mismatched++; $display("[TB] FAIL perf_stall: got %0d want 3", stall_cycles); end
        compared++; if (fetch_count !== 32'd1) begin mismatched++; $display("[TB] FAIL perf_fetch: got %0d want 1", fetch_count); end
`endif
        stall = 1'b0;
        step();
        compared++; if (if_id_pc_plus4 !== 32'h8) begin mismatched++; $display("[TB] FAIL unstall_pc4: got %h want 8", if_id_pc_plus4); end
        compared++; if (if_id_instr !== mem_word(32'h4)) begin mismatched++; $display("[TB] FAIL unstall_instr: got %h want %h", if_id_instr, mem_word(32'h4)); end
        compared++; if (imem_bus.imem_addr !== 32'h8) begin mismatched++; $display("[TB] FAIL unstall_addr: got %h want 8", imem_bus.imem_addr); end
        compared++; if (imem_bus.imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL unstall_req: got %b want 1", imem_bus.imem_req); end
        step();
        compared++; if (if_id_pc_plus4 !== 32'hC) begin mismatched++; $display("[TB] FAIL unstall_pc4_b: got %h want c", if_id_pc_plus4); end
        step();
        compared++; if (if_id_pc_plus4 !== 32'h10) begin mismatched++; $display("[TB] FAIL unstall_pc4_c: got %h want 10", if_id_pc_plus4); end
        compared++; if (if_id_instr !== mem_word(32'hC)) begin mismatched++; $display("[TB] FAIL unstall_instr_c: got %h want %h", if_id_instr, mem_word(32'hC)); end
    endtask

    task automatic test_discard();
        do_reset(1'b0);
        step();
        compared++; if (if_id_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL wait_valid: got %b want 0", if_id_valid); end
        redirect = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        compared++; if (imem_bus.imem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL discard_addr: got %h want 0", imem_bus.imem_addr); end
        compared++; if (imem_bus.imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL discard_req: got %b want 1", imem_bus.imem_req); end
        step();
        compared++; if (imem_bus.imem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL discard_addr2: got %h want 0", imem_bus.imem_addr); end
        compared++; if (if_id_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL discard_valid: got %b want 0", if_id_valid); end
        ready = 1'b1;
        step();
        compared++; if (imem_bus.imem_addr !== 32'h40) begin mismatched++; $display("[TB] FAIL discard_next_addr: got %h want 40", imem_bus.imem_addr); end
        compared++; if (if_id_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL discard_drop: got %b want 0", if_id_valid); end
        step();
        compared++; if (if_id_pc_plus4 !== 32'h44) begin mismatched++; $display("[TB] FAIL discard_pc4: got %h want 44", if_id_pc_plus4); end
        compared++; if (if_id_instr !== mem_word(32'h40)) begin mismatched++; $display("[TB] FAIL discard_instr: got %h want %h", if_id_instr, mem_word(32'h40)); end
    endtask

    task automatic test_redirect_stall();
        do_reset(1'b1);
        step();
        redirect = 1'b1;
        stall = 1'b1;
        redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        stall = 1'b0;
        compared++; if (if_id_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL redir_valid: got %b want 0", if_id_valid); end
        compared++; if (fetch_bubble !== 1'b1) begin mismatched++; $display("[TB] FAIL redir_bubble: got %b want 1", fetch_bubble); end
        compared++; if (imem_bus.imem_addr !== 32'h100) begin mismatched++; $display("[TB] FAIL redir_addr: got %h want 100", imem_bus.imem_addr); end
        step();
        compared++; if (if_id_pc_plus4 !== 32'h104) begin mismatched++; $display("[TB] FAIL redir_pc4: got %h want 104", if_id_pc_plus4); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        compared++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin mismatched++; $display("[TB] FAIL wrap_addr: got %h want fffffffc", imem_bus.imem_addr); end
        step();
        compared++; if (if_id_pc_plus4 !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_pc4: got %h want 0", if_id_pc_plus4); end
        compared++; if (if_id_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_valid: got %b want 1", if_id_valid); end
        compared++; if (imem_bus.imem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_next: got %h want 0", imem_bus.imem_addr); end
    endtask

    task automatic test_reset_in_hold();
        do_reset(1'b1);
        step();
        step();
        stall = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        compared++; if (imem_bus.imem_req !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_req: got %b want 0", imem_bus.imem_req); end
        compared++; if (if_id_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_valid: got %b want 0", if_id_valid); end
        compared++; if (if_id_instr !== 32'h0) begin mismatched++; $display("[TB] FAIL arst_instr: got %h want 0", if_id_instr); end
        compared++; if (if_id_pc_plus4 !== 32'h0) begin mismatched++; $display("[TB] FAIL arst_pc4: got %h want 0", if_id_pc_plus4); end
        compared++; if (imem_bus.imem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL arst_addr: got %h want 0", imem_bus.imem_addr); end
        @(negedge clk);
        stall = 1'b0;
        rst = 1'b0;
        #1;
        compared++; if (imem_bus.imem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL arst_rel_addr: got %h want 0", imem_bus.imem_addr); end
        compared++; if (imem_bus.imem_req !== 1'b1) begin mismatched++; $display("[TB] FAIL arst_rel_req: got %b want 1", imem_bus.imem_req); end
        step();
        compared++; if (if_id_pc_plus4 !== 32'h4) begin mismatched++; $display("[TB] FAIL arst_rel_pc4: got %h want 4", if_id_pc_plus4); end
        compared++; if (if_id_instr !== 32'h8C01_0004) begin mismatched++; $display("[TB] FAIL arst_rel_instr: got %h want 8c010004", if_id_instr); end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_fetch_stream();
        test_stall();
        test_discard();
        test_redirect_stall();
        test_wrap();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
